ram_arb: RTL and testbench
==========================

# ram_arb

Two-master arbiter and sequencer for the 32-bit byte-lane peripheral RAM (four 8-bit simple dual-port banks, one write port and one read port, 1-cycle synchronous read). It sits between the core data port (master 0) and the debug/loader port (master 1) on one side and the RAM's `wr_en_i`/`wr_addr_i`/`wr_data_i`/`rd_addr_i`/`rd_data_o` pins on the other. Each cycle it grants at most one request, routes the read data back to the owning master and holds the response until that master consumes it.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: master address width.
- `DATA_WIDTH`, default 32: data width; must be 32 (four byte lanes).
- `RAM_ADDR_WIDTH`, default 14: byte-address bits decoded by the RAM; the word index is `addr[RAM_ADDR_WIDTH-1:2]`.

Ports:
- `clk` in 1: single clock for the block and the RAM.
- `rst` in 1: synchronous, active-high reset.
- `mN_req_i` in 1 (N=0,1): request valid.
- `mN_we_i` in 1: 1 means write, 0 means read.
- `mN_addr_i` in ADDR_WIDTH: byte address.
- `mN_be_i` in 4: byte enables for writes; ignored on reads.
- `mN_wdata_i` in DATA_WIDTH: write data.
- `mN_gnt_o` out 1: request accepted this cycle.
- `mN_rsp_valid_o` out 1: response valid.
- `mN_rsp_data_o` out DATA_WIDTH: read data; 0 for write responses.
- `mN_rsp_ready_i` in 1: master accepts the response.
- `ram_wr_en_o` out 4: per-bank write enable.
- `ram_wr_addr_o` out ADDR_WIDTH: write address.
- `ram_wr_data_o` out DATA_WIDTH: write data.
- `ram_rd_addr_o` out ADDR_WIDTH: read address.
- `ram_rd_data_i` in DATA_WIDTH: RAM read data, valid the cycle after the read address is presented.

## Operation
- **Eligibility.** Master N is eligible when `mN_req_i=1` and its response slot is free. The slot is free when no response is pending, or when the pending response is being consumed this cycle (`rsp_valid & rsp_ready`).
- **Grant.** Grant is combinational from eligibility and the priority state. At most one `gnt` is high per cycle, and `gnt` is never high without `req`.
- **Granted write.**
  - `ram_wr_en_o = be`, `ram_wr_addr_o = addr`, `ram_wr_data_o = wdata`, all in the grant cycle.
  - The RAM stores the data at that cycle's clock edge.
  - `be=4'b0000` is legal: nothing is stored and the write still gets a response.
- **Granted read.** `ram_rd_addr_o = addr` in the grant cycle.
- **Idle RAM pins.** With no grant: `ram_wr_en_o=0`, and the other RAM outputs keep their last values (no spurious writes).
- **Address alignment.** `addr[1:0]` is ignored; addresses are word-aligned by the RAM index.
- **Response per master** (per-master state: `IDLE`, `RSP_LIVE`, `RSP_HELD`):
  - `IDLE` → `RSP_LIVE` on grant.
  - `RSP_LIVE` (cycle after the grant): `rsp_valid=1`. `rsp_data = ram_rd_data_i` for a read, 0 for a write.
    - If `rsp_ready=1`, go to `IDLE`, or stay in `RSP_LIVE` if re-granted the same cycle.
    - Otherwise capture `rsp_data` into a hold register and go to `RSP_HELD`.
  - `RSP_HELD`: `rsp_valid=1` and `rsp_data` comes from the hold register. On `rsp_ready` go to `IDLE`, or to `RSP_LIVE` if re-granted the same cycle.
- **Independence.** Held data stays stable even while the other master keeps driving new read addresses.
- **Arbitration.** Round-robin when `RAM_ARB_RR_EN` is defined (see Configuration).
  - A 1-bit `last` register records the last granted master.
  - On contention the master that is not `last` wins.
  - A lone eligible master always wins.
  - `last` updates only when a grant occurs.

## Timing
- **Reset values:**
  - All `gnt`, `rsp_valid` and `ram_wr_en_o` = 0.
  - `rsp_data`, `ram_*_addr_o`, `ram_wr_data_o` = 0.
  - Both response FSMs = `IDLE`.
  - `last` = 1, so master 0 wins the first contention.
- **Latency.** Grant in cycle T gives `rsp_valid` in T+1. Minimum cycles per request is 1, with full back-to-back throughput for a master whose `rsp_ready` is held high.
- **Handshake rules.**
  - A master must hold `req` and the request fields stable until `gnt`.
  - `rsp_valid` with its data stays stable until `rsp_ready`.
- **Reset mid-operation.** When `rst=1` at an edge, pending and held responses are discarded and the outputs return to their reset values the next cycle. A write granted in the same cycle as `rst=1` is suppressed: `ram_wr_en_o` is forced to 0 while `rst` is high.

## Configuration
- `RAM_ARB_RR_EN`:
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority. Master 0 always wins contention, the `last` register is not built, and master 1 is granted only when master 0 is not eligible.

## Test plan
- **Reset.** Hold `rst=1` for 3 cycles with both `req=1` → no `gnt`, `ram_wr_en_o=0`, both `rsp_valid=0`.
- **Write then read.** m0 writes `0xDEADBEEF` to `0x100` with `be=4'b1111`, then reads `0x100` → write `rsp_valid` at T+1 with data 0; read `rsp_data=0xDEADBEEF` one cycle after its grant.
- **Byte write.** m1 writes `0x000000AA` with `be=4'b0001` to `0x100` (after the scenario above), then m0 reads `0x100` → `0xDEADBEAA`.
- **Contention (RR).** Both masters request reads continuously with `rsp_ready=1` → grants alternate m0, m1, m0, m1…, starting with m0. Without `RAM_ARB_RR_EN`, m0 is granted every cycle and m1 never.
- **Backpressure.** m0 reads `0x100` (`0xDEADBEAA`) with `rsp_ready=0` for 4 cycles while m1 reads `0x200` each cycle:
  - m0 `rsp_data` stays `0xDEADBEAA`.
  - m0 gets no `gnt` until it raises `rsp_ready`.
  - m0 is then re-grantable in that same cycle.
- **Reset mid-read.** Assert `rst` in the cycle after an m1 read grant → m1 `rsp_valid` drops next cycle, and no response reappears after reset is released.

Source files
------------

// File: rtl/ram_arb.sv
// ram_arb: two-master arbiter/sequencer for the 4-bank byte-lane peripheral RAM.
// Ports: clk, rst (sync, active high); per master mN_req/we/addr/be/wdata in,
//   mN_gnt/rsp_valid/rsp_data out, mN_rsp_ready in; ram_wr_en/wr_addr/wr_data/
//   rd_addr out, ram_rd_data in (1-cycle read latency).
// Build option: RAM_ARB_RR_EN selects round-robin, otherwise m0 fixed priority.
module ram_arb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [3:0]            m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] m0_rsp_data_o,
  input  logic                  m0_rsp_ready_i,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [3:0]            m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] m1_rsp_data_o,
  input  logic                  m1_rsp_ready_i,
  output logic [3:0]            ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

  if (DATA_WIDTH != 32 || RAM_ADDR_WIDTH < 3 ||
      RAM_ADDR_WIDTH > ADDR_WIDTH) begin : g_cfg_err
    $error("ram_arb: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE, RSP_LIVE, RSP_HELD
  } rsp_st_e;

  logic [1:0]            req, we, rdy;
  logic [1:0]            elig, gnt, rsp_valid;
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [3:0]            be [2];
  logic [DATA_WIDTH-1:0] wdata [2];

  rsp_st_e               st_q [2];
  rsp_st_e               st_d [2];
  logic [1:0]            rd_q;
  logic [DATA_WIDTH-1:0] hold_q [2];
  logic [DATA_WIDTH-1:0] live_data [2];
  logic [DATA_WIDTH-1:0] rsp_data [2];

  logic                  prefer_m0;
  logic                  sel, wr_go, rd_go;
  logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  assign req      = {m1_req_i, m0_req_i};
  assign we       = {m1_we_i, m0_we_i};
  assign rdy      = {m1_rsp_ready_i, m0_rsp_ready_i};
  assign addr[0]  = m0_addr_i;
  assign addr[1]  = m1_addr_i;
  assign be[0]    = m0_be_i;
  assign be[1]    = m1_be_i;
  assign wdata[0] = m0_wdata_i;
  assign wdata[1] = m1_wdata_i;

  // A slot frees up in the same cycle its response is consumed.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      elig[n] = req[n] & ((st_q[n] == IDLE) | rdy[n]);
    end
  end

`ifdef RAM_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

  assign prefer_m0 = last_q;
`else
  assign prefer_m0 = 1'b1;
`endif

  // No grant under reset, so a colliding write never reaches the banks.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (elig[0] && (prefer_m0 || !elig[1])) begin
        gnt = 2'b01;
      end else if (elig[1]) begin
        gnt = 2'b10;
      end
    end
  end

  assign sel   = gnt[1];
  assign wr_go = (|gnt) & we[sel];
  assign rd_go = (|gnt) & ~we[sel];

  assign ram_wr_en_o   = wr_go ? be[sel] : 4'b0000;
  assign ram_wr_addr_o = wr_go ? addr[sel] : wr_addr_q;
  assign ram_wr_data_o = wr_go ? wdata[sel] : wr_data_q;
  assign ram_rd_addr_o = rd_go ? addr[sel] : rd_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      if (wr_go) begin
        wr_addr_q <= addr[sel];
        wr_data_q <= wdata[sel];
      end
      if (rd_go) begin
        rd_addr_q <= addr[sel];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        st_q[n] <= IDLE;
      end else begin
        st_q[n] <= st_d[n];
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      st_d[n] = st_q[n];
      unique case (st_q[n])
        IDLE: begin
          if (gnt[n]) st_d[n] = RSP_LIVE;
        end
        RSP_LIVE, RSP_HELD: begin
          if (gnt[n]) begin
            st_d[n] = RSP_LIVE;
          end else if (rdy[n]) begin
            st_d[n] = IDLE;
          end else begin
            st_d[n] = RSP_HELD;
          end
        end
        default: st_d[n] = IDLE;
      endcase
    end
  end

  // rd_q remembers whether the outstanding request was a read.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        rd_q[n]   <= 1'b0;
        hold_q[n] <= '0;
      end else begin
        if (gnt[n]) begin
          rd_q[n] <= ~we[n];
        end
        if (st_q[n] == RSP_LIVE && !rdy[n]) begin
          hold_q[n] <= live_data[n];
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      live_data[n] = rd_q[n] ? ram_rd_data_i : '0;
      rsp_valid[n] = (st_q[n] != IDLE);
      rsp_data[n]  = '0;
      unique case (1'b1)
        st_q[n] == RSP_LIVE: rsp_data[n] = live_data[n];
        st_q[n] == RSP_HELD: rsp_data[n] = hold_q[n];
        default: ;
      endcase
    end
  end

  assign m0_gnt_o       = gnt[0];
  assign m1_gnt_o       = gnt[1];
  assign m0_rsp_valid_o = rsp_valid[0];
  assign m1_rsp_valid_o = rsp_valid[1];
  assign m0_rsp_data_o  = rsp_data[0];
  assign m1_rsp_data_o  = rsp_data[1];

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: directed and random checks of ram_arb against a
// transaction-level model, with a behavioural 4-bank RAM attached.
module tb_ram_arb;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  logic [1:0]  req, we, rdy;
  logic [31:0] addr [2];
  logic [3:0]  be [2];
  logic [31:0] wd [2];

  logic        m0_gnt, m1_gnt, m0_rv, m1_rv;
  logic [31:0] m0_rd, m1_rd;
  logic [3:0]  ram_wr_en;
  logic [31:0] ram_wr_addr, ram_wr_data;
  logic [31:0] ram_rd_addr, ram_rd_data;

  ram_arb #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RAM_ADDR_WIDTH(14)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .m0_req_i      (req[0]),
    .m0_we_i       (we[0]),
    .m0_addr_i     (addr[0]),
    .m0_be_i       (be[0]),
    .m0_wdata_i    (wd[0]),
    .m0_gnt_o      (m0_gnt),
    .m0_rsp_valid_o(m0_rv),
    .m0_rsp_data_o (m0_rd),
    .m0_rsp_ready_i(rdy[0]),
    .m1_req_i      (req[1]),
    .m1_we_i       (we[1]),
    .m1_addr_i     (addr[1]),
    .m1_be_i       (be[1]),
    .m1_wdata_i    (wd[1]),
    .m1_gnt_o      (m1_gnt),
    .m1_rsp_valid_o(m1_rv),
    .m1_rsp_data_o (m1_rd),
    .m1_rsp_ready_i(rdy[1]),
    .ram_wr_en_o   (ram_wr_en),
    .ram_wr_addr_o (ram_wr_addr),
    .ram_wr_data_o (ram_wr_data),
    .ram_rd_addr_o (ram_rd_addr),
    .ram_rd_data_i (ram_rd_data)
  );

  // Behavioural RAM: four byte banks, synchronous read.
  logic [31:0] mem [4096];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wr_en[b]) begin
          mem[ram_wr_addr[13:2]][8*b +: 8] <= ram_wr_data[8*b +: 8];
        end
      end
    end
    ram_rd_data <= mem[ram_rd_addr[13:2]];
  end

  // Reference model state
  int          chk_n  = 0;
  int          fail_n = 0;
  logic [1:0]  pend;
  logic [31:0] pdat [2];
  logic [1:0]  gx;
  logic [31:0] lwa, lwd, lra;
  logic [31:0] ref_mem [4096];
`ifdef RAM_ARB_RR_EN
  logic        last_g;
`endif

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    chk_n++;
    assert (obs === exp) else begin
      fail_n++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(int n, logic r, logic w, logic [31:0] a,
                       logic [3:0] b, logic [31:0] d);
    req[n]  = r;
    we[n]   = w;
    addr[n] = a;
    be[n]   = b;
    wd[n]   = d;
  endtask

  task automatic settle();
    #4;
  endtask

  // Predict this cycle, compare every output, then advance one clock.
  task automatic eval();
    logic        e0, e1;
    logic [3:0]  xen;
    logic [31:0] xwa, xwd, xra;
    logic [31:0] rdat [2];
    logic [1:0]  rvs;
    int          w;
    e0 = req[0] && (!pend[0] || rdy[0]);
    e1 = req[1] && (!pend[1] || rdy[1]);
    gx = 2'b00;
    if (!rst) begin
      if (e0 && e1) begin
`ifdef RAM_ARB_RR_EN
        gx = last_g ? 2'b01 : 2'b10;
`else
        gx = 2'b01;
`endif
      end else begin
        gx = {e1, e0};
      end
    end
    xen = 4'b0000;
    xwa = lwa;
    xwd = lwd;
    xra = lra;
    for (int n = 0; n < 2; n++) begin
      if (gx[n]) begin
        if (we[n]) begin
          xen = be[n];
          xwa = addr[n];
          xwd = wd[n];
        end else begin
          xra = addr[n];
        end
      end
    end
    rdat[0] = m0_rd;
    rdat[1] = m1_rd;
    rvs = {m1_rv, m0_rv};
    check("m0_gnt", 32'(m0_gnt), 32'(gx[0]));
    check("m1_gnt", 32'(m1_gnt), 32'(gx[1]));
    for (int n = 0; n < 2; n++) begin
      check($sformatf("m%0d_rsp_valid", n), 32'(rvs[n]), 32'(pend[n]));
      if (pend[n]) begin
        check($sformatf("m%0d_rsp_data", n), rdat[n], pdat[n]);
      end
    end
    check("ram_wr_en", 32'(ram_wr_en), 32'(xen));
    check("ram_wr_addr", ram_wr_addr, xwa);
    check("ram_wr_data", ram_wr_data, xwd);
    check("ram_rd_addr", ram_rd_addr, xra);
    if (rst) begin
      pend = 2'b00;
      lwa = '0;
      lwd = '0;
      lra = '0;
`ifdef RAM_ARB_RR_EN
      last_g = 1'b1;
`endif
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (gx[n]) begin
          w = int'(addr[n][13:2]);
          if (we[n]) begin
            for (int b = 0; b < 4; b++) begin
              if (be[n][b]) ref_mem[w][8*b +: 8] = wd[n][8*b +: 8];
            end
            pdat[n] = '0;
          end else begin
            pdat[n] = ref_mem[w];
          end
          pend[n] = 1'b1;
        end else if (pend[n] && rdy[n]) begin
          pend[n] = 1'b0;
        end
      end
      lwa = xwa;
      lwd = xwd;
      lra = xra;
`ifdef RAM_ARB_RR_EN
      if (|gx) last_g = gx[1];
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    eval();
  endtask

  initial begin
    pend = 2'b00;
    gx   = 2'b00;
    lwa  = '0;
    lwd  = '0;
    lra  = '0;
`ifdef RAM_ARB_RR_EN
    last_g = 1'b1;
`endif
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    pdat[0] = '0;
    pdat[1] = '0;

    // Reset with both masters requesting
    rst = 1'b1;
    clr = 1'b1;
    rdy = 2'b11;
    drive(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b1, 32'h4, 4'hF, 32'h1234);
    @(posedge clk);
    #1;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Contention straight out of reset
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      settle();
`ifdef RAM_ARB_RR_EN
      check("cont_m0_gnt", 32'(m0_gnt), 32'(i % 2 == 0));
`else
      check("cont_m0_gnt", 32'(m0_gnt), 32'd1);
`endif
      eval();
    end
    req = 2'b00;
    step();
    step();

    // Full-word write then read
    drive(0, 1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    settle();
    check("wr_gnt", 32'(m0_gnt), 32'd1);
    check("wr_en", 32'(ram_wr_en), 32'hF);
    eval();
    drive(0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    settle();
    check("wr_rsp_valid", 32'(m0_rv), 32'd1);
    check("wr_rsp_data", m0_rd, 32'h0);
    eval();
    req[0] = 1'b0;
    settle();
    check("rd_data", m0_rd, 32'hDEADBEEF);
    eval();

    // Byte-lane write from m1, read back by m0
    drive(1, 1'b1, 1'b1, 32'h100, 4'h1, 32'h000000AA);
    step();
    req[1] = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h101, 4'h0, 32'h0);
    step();
    req[0] = 1'b0;
    settle();
    check("byte_rd_data", m0_rd, 32'hDEADBEAA);
    eval();

    // m0 backpressure while m1 streams reads
    rdy[0] = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    step();
    drive(1, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("bp_hold_data", m0_rd, 32'hDEADBEAA);
      check("bp_no_gnt", 32'(m0_gnt), 32'd0);
      check("bp_m1_gnt", 32'(m1_gnt), 32'd1);
      eval();
    end
    rdy[0] = 1'b1;
    settle();
    check("bp_regrant", 32'(m0_gnt), 32'd1);
    check("bp_last_data", m0_rd, 32'hDEADBEAA);
    eval();
    req = 2'b00;
    step();
    step();

    // Reset the cycle after an m1 read grant
    drive(1, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0);
    step();
    req[1] = 1'b0;
    rst = 1'b1;
    settle();
    check("rst_rv_before", 32'(m1_rv), 32'd1);
    eval();
    rst = 1'b0;
    settle();
    check("rst_rv_after", 32'(m1_rv), 32'd0);
    eval();
    for (int i = 0; i < 3; i++) step();

    // Random traffic; request fields are held until granted
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!(req[n] && !gx[n])) begin
          drive(n, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
                $urandom);
        end
        rdy[n] = $urandom_range(0, 3) != 0;
      end
      rst = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", chk_n, fail_n);
    $finish;
  end

endmodule
